mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates data-memory port 2 between the pipeline's load/store stage and an
// external programmer; the programmer owns the port for a whole session while the CPU is stalled.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_RD,
    input  logic              CPU_WR,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [31:0]       CPU_DIN,
    input  logic [1:0]        CPU_SIZE,
    input  logic              CPU_SIGN,
    input  logic              PRG_SESSION,
    input  logic              PRG_WE,
    input  logic [ADDR_W-1:0] PRG_ADDR,
    input  logic [31:0]       PRG_DATA,
    output logic [ADDR_W-1:0] MEM_ADDR2,
    output logic [31:0]       MEM_DIN2,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    output logic              MEM_READ2,
    output logic              MEM_WRITE2,
    output logic              CPU_STALL,
    output logic              CPU_RVALID,
    output logic              PRG_ACK,
    output logic [CNT_W-1:0]  PRG_COUNT,
    output logic              ERR
);

    typedef enum logic [1:0] {IDLE, CPU_RDW, PRG, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         size_q, size_d;
    logic               sign_q, sign_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  mem_addr;
    logic [31:0]        mem_din;
    logic [1:0]         mem_size;
    logic               mem_sign;
    logic               mem_read;
    logic               mem_write;
    logic               stall;
    logic               rvalid;
    logic               ack;

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        sign_d    = sign_q;
        count_d   = count_q;
        err_d     = err_q;
        mem_addr  = '0;
        mem_din   = '0;
        mem_size  = 2'b00;
        mem_sign  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        stall     = 1'b0;
        rvalid    = 1'b0;
        ack       = 1'b0;

        case (state_q)
            IDLE, CPU_RDW: begin
                // The load issued last cycle returns now; a new request below may override size/sign.
                if (state_q == CPU_RDW) begin
                    rvalid   = 1'b1;
                    mem_size = size_q;
                    mem_sign = sign_q;
                end
                if (PRG_SESSION) begin
                    stall   = 1'b1;
                    state_d = PRG;
                    count_d = '0;
                end else if (CPU_WR) begin
                    mem_write = 1'b1;
                    mem_addr  = CPU_ADDR;
                    mem_din   = CPU_DIN;
                    mem_size  = CPU_SIZE;
                    mem_sign  = 1'b0;
                    state_d   = IDLE;
                end else if (CPU_RD) begin
                    mem_read = 1'b1;
                    mem_addr = CPU_ADDR;
                    mem_size = CPU_SIZE;
                    mem_sign = CPU_SIGN;
                    size_d   = CPU_SIZE;
                    sign_d   = CPU_SIGN;
                    state_d  = CPU_RDW;
                end else begin
                    state_d = IDLE;
                end
                if (PRG_WE) begin
                    err_d = 1'b1;
                end
            end
            PRG: begin
                stall = 1'b1;
                if (PRG_WE) begin
                    mem_write = 1'b1;
                    mem_addr  = PRG_ADDR;
                    mem_din   = PRG_DATA;
                    mem_size  = 2'b10;
                    ack       = 1'b1;
                    count_d   = count_q + CNT_W'(1);
                end
                if (!PRG_SESSION) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                stall = 1'b1;
                if (PRG_WE) begin
                    err_d = 1'b1;
                end
                if (PRG_SESSION) begin
                    state_d = PRG;
                    count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (CPU_RD && CPU_WR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // While reset is held everything is quiet except the stall that freezes the pipeline.
    assign MEM_ADDR2  = RST ? '0 : mem_addr;
    assign MEM_DIN2   = RST ? '0 : mem_din;
    assign MEM_SIZE   = RST ? 2'b00 : mem_size;
    assign MEM_SIGN   = RST ? 1'b0 : mem_sign;
    assign MEM_READ2  = RST ? 1'b0 : mem_read;
    assign MEM_WRITE2 = RST ? 1'b0 : mem_write;
    assign CPU_STALL  = RST ? 1'b1 : stall;
    assign CPU_RVALID = RST ? 1'b0 : rvalid;
    assign PRG_ACK    = RST ? 1'b0 : ack;
    assign PRG_COUNT  = RST ? '0 : count_q;
    assign ERR        = RST ? 1'b0 : err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: CPU loads/stores, programmer sessions,
// release handover, protocol errors and reset.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic              CPU_RD, CPU_WR;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [31:0]       CPU_DIN;
    logic [1:0]        CPU_SIZE;
    logic              CPU_SIGN;
    logic              PRG_SESSION, PRG_WE;
    logic [ADDR_W-1:0] PRG_ADDR;
    logic [31:0]       PRG_DATA;
    logic [ADDR_W-1:0] MEM_ADDR2;
    logic [31:0]       MEM_DIN2;
    logic [1:0]        MEM_SIZE;
    logic              MEM_SIGN, MEM_READ2, MEM_WRITE2;
    logic              CPU_STALL, CPU_RVALID, PRG_ACK;
    logic [CNT_W-1:0]  PRG_COUNT;
    logic              ERR;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_RD(CPU_RD), .CPU_WR(CPU_WR), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN),
        .PRG_SESSION(PRG_SESSION), .PRG_WE(PRG_WE), .PRG_ADDR(PRG_ADDR), .PRG_DATA(PRG_DATA),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_READ2(MEM_READ2), .MEM_WRITE2(MEM_WRITE2),
        .CPU_STALL(CPU_STALL), .CPU_RVALID(CPU_RVALID), .PRG_ACK(PRG_ACK),
        .PRG_COUNT(PRG_COUNT), .ERR(ERR)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change 1ns after the edge, outputs are sampled 2ns later
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_idle();
        CPU_RD = 0; CPU_WR = 0; CPU_ADDR = '0; CPU_DIN = '0; CPU_SIZE = 2'b00; CPU_SIGN = 0;
        PRG_SESSION = 0; PRG_WE = 0; PRG_ADDR = '0; PRG_DATA = '0;
    endtask

    task automatic drive_prg(input logic sess, input logic we, input logic [31:0] a, input logic [31:0] d);
        PRG_SESSION = sess; PRG_WE = we; PRG_ADDR = a; PRG_DATA = d;
    endtask

    initial begin
        drive_idle();
        RST = 1;
        #1;
        next_cycle();
        settle();
        check_eq("rst_stall", CPU_STALL, 1);
        check_eq("rst_wr", MEM_WRITE2, 0);
        check_eq("rst_rvalid", CPU_RVALID, 0);
        check_eq("rst_count", PRG_COUNT, 0);
        check_eq("rst_err", ERR, 0);
        next_cycle();
        RST = 0;

        // single store
        CPU_WR = 1; CPU_ADDR = 32'h100; CPU_DIN = 32'hDEADBEEF; CPU_SIZE = 2'b10;
        settle();
        check_eq("st_we", MEM_WRITE2, 1);
        check_eq("st_addr", MEM_ADDR2, 32'h100);
        check_eq("st_din", MEM_DIN2, 32'hDEADBEEF);
        check_eq("st_size", MEM_SIZE, 2'b10);
        check_eq("st_stall", CPU_STALL, 0);
        check_eq("st_rd", MEM_READ2, 0);
        next_cycle();

        // back-to-back loads
        drive_idle();
        CPU_RD = 1; CPU_ADDR = 32'h200; CPU_SIZE = 2'b01; CPU_SIGN = 1;
        settle();
        check_eq("ld1_rd", MEM_READ2, 1);
        check_eq("ld1_addr", MEM_ADDR2, 32'h200);
        check_eq("ld1_size", MEM_SIZE, 2'b01);
        check_eq("ld1_sign", MEM_SIGN, 1);
        check_eq("ld1_rvalid", CPU_RVALID, 0);
        next_cycle();
        CPU_ADDR = 32'h204; CPU_SIZE = 2'b00; CPU_SIGN = 1;
        settle();
        check_eq("ld2_rd", MEM_READ2, 1);
        check_eq("ld2_addr", MEM_ADDR2, 32'h204);
        check_eq("ld2_rvalid", CPU_RVALID, 1);
        check_eq("ld2_size", MEM_SIZE, 2'b00);
        check_eq("ld2_stall", CPU_STALL, 0);
        next_cycle();
        drive_idle();
        settle();
        check_eq("ld3_rvalid", CPU_RVALID, 1);
        check_eq("ld3_size_held", MEM_SIZE, 2'b00);
        check_eq("ld3_sign_held", MEM_SIGN, 1);
        check_eq("ld3_rd", MEM_READ2, 0);
        check_eq("ld3_addr", MEM_ADDR2, 0);
        next_cycle();
        settle();
        check_eq("ld4_rvalid", CPU_RVALID, 0);
        check_eq("ld4_size", MEM_SIZE, 0);
        check_eq("ld_err", ERR, 0);

        // load racing the start of a programming session
        CPU_RD = 1; CPU_ADDR = 32'h300; CPU_SIZE = 2'b10;
        settle();
        check_eq("race_rd", MEM_READ2, 1);
        next_cycle();
        drive_idle();
        PRG_SESSION = 1;
        CPU_RD = 1; CPU_ADDR = 32'h304;
        settle();
        check_eq("race_rvalid", CPU_RVALID, 1);
        check_eq("race_stall", CPU_STALL, 1);
        check_eq("race_no_rd", MEM_READ2, 0);
        next_cycle();
        CPU_RD = 0;
        drive_prg(1, 1, 32'h10, 32'h11111111);
        settle();
        check_eq("prg1_ack", PRG_ACK, 1);
        check_eq("prg1_we", MEM_WRITE2, 1);
        check_eq("prg1_addr", MEM_ADDR2, 32'h10);
        check_eq("prg1_din", MEM_DIN2, 32'h11111111);
        check_eq("prg1_size", MEM_SIZE, 2'b10);
        check_eq("prg1_stall", CPU_STALL, 1);
        check_eq("prg1_count", PRG_COUNT, 0);
        check_eq("prg1_rvalid", CPU_RVALID, 0);
        next_cycle();
        drive_prg(1, 0, 32'h0, 32'h0);
        settle();
        check_eq("prg_gap_ack", PRG_ACK, 0);
        check_eq("prg_gap_we", MEM_WRITE2, 0);
        check_eq("prg_gap_count", PRG_COUNT, 1);
        next_cycle();
        drive_prg(1, 1, 32'h14, 32'h22222222);
        settle();
        check_eq("prg2_ack", PRG_ACK, 1);
        next_cycle();
        drive_prg(1, 1, 32'h18, 32'h33333333);
        settle();
        check_eq("prg3_ack", PRG_ACK, 1);
        check_eq("prg3_count", PRG_COUNT, 2);
        next_cycle();
        drive_prg(1, 0, 32'h0, 32'h0);
        CPU_WR = 1; CPU_ADDR = 32'h400; CPU_DIN = 32'hCAFEF00D; CPU_SIZE = 2'b10;
        settle();
        check_eq("prg_count3", PRG_COUNT, 3);
        check_eq("prg_cpu_denied", MEM_WRITE2, 0);
        check_eq("prg_stall", CPU_STALL, 1);
        next_cycle();

        // session ends with a store held pending
        PRG_SESSION = 0;
        settle();
        check_eq("fall_stall", CPU_STALL, 1);
        check_eq("fall_we", MEM_WRITE2, 0);
        next_cycle();
        settle();
        check_eq("rel_stall", CPU_STALL, 1);
        check_eq("rel_we", MEM_WRITE2, 0);
        check_eq("rel_count", PRG_COUNT, 3);
        next_cycle();
        settle();
        check_eq("post_we", MEM_WRITE2, 1);
        check_eq("post_addr", MEM_ADDR2, 32'h400);
        check_eq("post_din", MEM_DIN2, 32'hCAFEF00D);
        check_eq("post_stall", CPU_STALL, 0);
        check_eq("post_count", PRG_COUNT, 3);
        check_eq("post_err", ERR, 0);
        next_cycle();

        // write on the falling edge, then re-entry from RELEASE
        drive_idle();
        PRG_SESSION = 1;
        next_cycle();
        drive_prg(0, 1, 32'h20, 32'h44444444);
        settle();
        check_eq("fallwe_ack", PRG_ACK, 1);
        check_eq("fallwe_we", MEM_WRITE2, 1);
        next_cycle();
        drive_prg(1, 0, 32'h0, 32'h0);
        settle();
        check_eq("rerise_stall", CPU_STALL, 1);
        check_eq("rerise_count", PRG_COUNT, 1);
        check_eq("rerise_we", MEM_WRITE2, 0);
        next_cycle();
        settle();
        check_eq("reenter_count", PRG_COUNT, 0);
        check_eq("reenter_stall", CPU_STALL, 1);
        for (int i = 0; i < 5; i++) begin
            drive_prg(1, 1, 32'h40 + 32'(4 * i), $urandom_range(0, 32'hFFFF));
            settle();
            check_eq("burst_ack", PRG_ACK, 1);
            next_cycle();
        end
        drive_prg(1, 0, 32'h0, 32'h0);
        settle();
        check_eq("burst_count", PRG_COUNT, 5);

        // reset in the middle of a session
        next_cycle();
        RST = 1;
        settle();
        check_eq("rstprg_stall", CPU_STALL, 1);
        check_eq("rstprg_count", PRG_COUNT, 0);
        next_cycle();
        drive_idle();
        settle();
        check_eq("rstheld_stall", CPU_STALL, 1);
        check_eq("rstheld_count", PRG_COUNT, 0);
        next_cycle();
        RST = 0;
        CPU_WR = 1; CPU_ADDR = 32'h500; CPU_DIN = 32'h5; CPU_SIZE = 2'b00;
        settle();
        check_eq("afterrst_stall", CPU_STALL, 0);
        check_eq("afterrst_we", MEM_WRITE2, 1);
        check_eq("afterrst_count", PRG_COUNT, 0);
        check_eq("afterrst_err", ERR, 0);
        next_cycle();

        // stray programmer strobe outside a session
        drive_idle();
        PRG_WE = 1; PRG_ADDR = 32'h60; PRG_DATA = 32'h66;
        settle();
        check_eq("stray_we", MEM_WRITE2, 0);
        check_eq("stray_ack", PRG_ACK, 0);
        next_cycle();
        PRG_WE = 0;
        settle();
        check_eq("stray_err", ERR, 1);
        next_cycle();
        next_cycle();
        settle();
        check_eq("stray_err_sticky", ERR, 1);

        // simultaneous load and store: store wins
        RST = 1;
        next_cycle();
        RST = 0;
        CPU_RD = 1; CPU_WR = 1; CPU_ADDR = 32'h700; CPU_DIN = 32'h77; CPU_SIZE = 2'b10;
        settle();
        check_eq("both_err_clr", ERR, 0);
        check_eq("both_we", MEM_WRITE2, 1);
        check_eq("both_rd", MEM_READ2, 0);
        next_cycle();
        drive_idle();
        settle();
        check_eq("both_err", ERR, 1);
        check_eq("both_rvalid", CPU_RVALID, 0);
        next_cycle();

        // in-flight load abandoned by reset
        CPU_RD = 1; CPU_ADDR = 32'h800;
        next_cycle();
        drive_idle();
        RST = 1;
        next_cycle();
        RST = 0;
        settle();
        check_eq("abandon_rvalid", CPU_RVALID, 0);
        check_eq("abandon_err", ERR, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
